// File: rtl/pc_hazard_sequencer_if.sv
// pc_hazard_sequencer_if
//   Bundle of the fetch/decode/execute control signals around the PC
//   hazard sequencer.
//   slave  : the sequencer (consumes pipeline status, drives controls)
//   master : the pipeline side / testbench (drives status, sees controls)
//   Status : pc_cur, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
//            ex_redirect, ex_target, imem_ready
//   Control: pc_hold, pc_next, if_id_hold, if_id_flush, id_ex_flush,
//            fetch_timeout, state_dbg, stall_cnt, flush_cnt
interface pc_hazard_sequencer_if;
  logic [31:0] pc_cur;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_ready;
  logic        pc_hold;
  logic [31:0] pc_next;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        fetch_timeout;
  logic [1:0]  state_dbg;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport slave (
    input  pc_cur, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, ex_target, imem_ready,
    output pc_hold, pc_next, if_id_hold, if_id_flush, id_ex_flush,
           fetch_timeout, state_dbg, stall_cnt, flush_cnt
  );

  modport master (
    output pc_cur, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, ex_target, imem_ready,
    input  pc_hold, pc_next, if_id_hold, if_id_flush, id_ex_flush,
           fetch_timeout, state_dbg, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pc_hazard_sequencer.sv
// pc_hazard_sequencer
//   Next-PC selection plus hold/flush sequencing for the PC register and
//   the IF/ID and ID/EX pipeline registers of the 5-stage RV32 pipeline.
//   Controls are Mealy (registered state + current inputs) so the
//   pipeline registers act on them at the same clock edge.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : pc_hazard_sequencer_if.slave (status in, controls out)
//   Parameters:
//     WAIT_LIMIT : consecutive IMEM wait cycles that set fetch_timeout
//     WCNT_W     : wait counter width, 2**WCNT_W > WAIT_LIMIT
//   Optional feature macro: PC_SEQ_PERF_CTR_EN builds the stall/flush
//   performance counters; otherwise they read as 0.
//
//   state    | meaning
//   RUN      | normal fetch/advance
//   STALL    | one-cycle bubble after a load-use hazard
//   REDIRECT | one cycle after an EX redirect, ID holds a bubble
//   WAIT     | waiting for instruction memory
module pc_hazard_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter int WCNT_W     = 8
) (
  input logic                  clk,
  input logic                  reset,
  pc_hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2,
    WAIT     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic              timeout_q;
  logic              lu;
  logic              redirect_take;
  logic              pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c;
  logic [31:0]       pc_next_c;

  assign lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
              ((bus.ex_rd == bus.id_rs1) ||
               (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

  assign wcnt_inc = (wcnt == {WCNT_W{1'b1}}) ? wcnt : wcnt + 1'b1;

  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    pc_next_c     = bus.pc_cur + 32'd4;
    pc_hold_c     = 1'b0;
    if_id_hold_c  = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    redirect_take = 1'b0;
    if (reset) begin
      state_nxt = RUN;
      wcnt_nxt  = '0;
    end else begin
      // Redirect is only honoured where EX can hold a real branch.
      if (bus.ex_redirect && (state != REDIRECT)) begin
        redirect_take = 1'b1;
        pc_next_c     = bus.ex_target;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        state_nxt     = REDIRECT;
        wcnt_nxt      = '0;
      end else if (lu && (state == RUN || state == WAIT)) begin
        pc_hold_c     = 1'b1;
        if_id_hold_c  = 1'b1;
        id_ex_flush_c = 1'b1;
        if (state == RUN) begin
          state_nxt = STALL;
        end else begin
          wcnt_nxt = wcnt_inc;
        end
      end else if (!bus.imem_ready) begin
        pc_hold_c     = 1'b1;
        if_id_flush_c = 1'b1;
        state_nxt     = WAIT;
        wcnt_nxt      = (state == WAIT) ? wcnt_inc : WCNT_W'(1);
      end else begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state_nxt == WAIT && wcnt_nxt == WCNT_W'(WAIT_LIMIT))
        timeout_q <= 1'b1;
    end
  end

`ifdef PC_SEQ_PERF_CTR_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold_c)     stall_q <= stall_q + 32'd1;
      if (redirect_take) flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

  assign bus.pc_hold       = pc_hold_c;
  assign bus.pc_next       = pc_next_c;
  assign bus.if_id_hold    = if_id_hold_c;
  assign bus.if_id_flush   = if_id_flush_c;
  assign bus.id_ex_flush   = id_ex_flush_c;
  assign bus.fetch_timeout = timeout_q;
  assign bus.state_dbg     = state;

endmodule
